// File: rtl/my_cpu_core.sv
// Parametrised four-register CPU core: ALU with carry/zero flags, conditional jumps,
// a hardware CALL/RET stack that faults on overflow/underflow, and a divided execution tick.
module my_cpu_core #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CLK_DIV     = 10
) (
    input  logic                clock,
    input  logic                Reset,
    output logic [ADDR_W-1:0]   instr_addr,
    input  logic [7+DATA_W:0]   instr_data,
    input  logic [DATA_W-1:0]   in_data,
    output logic [DATA_W-1:0]   out_data,
    output logic                out_strobe,
    output logic                carry,
    output logic                zero,
    output logic                fault
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int SI_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [0:0] {S_RUN, S_FAULT} state_t;

    state_t                        r_state, w_state_next;
    logic [DIV_W-1:0]              r_div;
    logic [ADDR_W-1:0]             r_pc;
    logic [3:0][DATA_W-1:0]        r_regs;
    logic [DATA_W-1:0]             r_out;
    logic                          r_carry, r_zero, r_strobe;
    logic [SP_W-1:0]               r_sp;
    logic [ADDR_W-1:0]             r_stack [STACK_DEPTH];

    logic                          w_tick, w_exec;
    logic [3:0]                    w_op;
    logic [1:0]                    w_rd, w_rs;
    logic [DATA_W-1:0]             w_imm, w_a, w_b, w_result;
    logic [DATA_W:0]               w_sum;
    logic [ADDR_W-1:0]             w_pc_next;
    logic                          w_wr_en, w_alu, w_out_we, w_push, w_pop;
    logic [SI_W-1:0]               w_push_idx, w_top_idx;

    assign w_tick     = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_exec     = (r_state == S_RUN) && w_tick;
    assign w_op       = instr_data[7+DATA_W:4+DATA_W];
    assign w_rd       = instr_data[3+DATA_W:2+DATA_W];
    assign w_rs       = instr_data[1+DATA_W:DATA_W];
    assign w_imm      = instr_data[DATA_W-1:0];
    assign w_a        = r_regs[w_rd];
    assign w_b        = r_regs[w_rs];
    assign w_push_idx = SI_W'(r_sp);
    assign w_top_idx  = SI_W'(r_sp - 1'b1);

    always_ff @(posedge clock) begin
        if (Reset) r_state <= S_RUN;
        else       r_state <= w_state_next;
    end

    // Decode and next-state; nothing is enabled unless RUN and on a tick.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_result     = '0;
        w_sum        = '0;
        w_wr_en      = 1'b0;
        w_alu        = 1'b0;
        w_out_we     = 1'b0;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        if (w_exec) begin
            w_pc_next = r_pc + 1'b1;
            case (w_op)
                4'h1: begin w_wr_en = 1'b1; w_result = w_b; end
                4'h2: begin w_wr_en = 1'b1; w_result = w_imm; end
                4'h3: begin w_alu = 1'b1; w_sum = {1'b0, w_a} + {1'b0, w_b}; end
                4'h4: begin w_alu = 1'b1; w_sum = {1'b0, w_a} + {1'b0, w_imm}; end
                4'h5: begin w_alu = 1'b1; w_sum = {1'b0, w_a} - {1'b0, w_b}; end
                4'h6: begin w_alu = 1'b1; w_sum = {1'b0, w_a & w_b}; end
                4'h7: begin w_alu = 1'b1; w_sum = {1'b0, w_a | w_b}; end
                4'h8: begin w_alu = 1'b1; w_sum = {1'b0, w_a ^ w_b}; end
                4'h9: begin w_wr_en = 1'b1; w_result = in_data; end
                4'hA: w_out_we = 1'b1;
                4'hB: w_pc_next = w_imm[ADDR_W-1:0];
                4'hC: if (!r_carry) w_pc_next = w_imm[ADDR_W-1:0];
                4'hD: if (r_zero)   w_pc_next = w_imm[ADDR_W-1:0];
                4'hE: begin
                    if (r_sp == SP_W'(STACK_DEPTH)) begin
                        w_state_next = S_FAULT;
                        w_pc_next    = r_pc;
                    end else begin
                        w_push    = 1'b1;
                        w_pc_next = w_imm[ADDR_W-1:0];
                    end
                end
                4'hF: begin
                    if (r_sp == '0) begin
                        w_state_next = S_FAULT;
                        w_pc_next    = r_pc;
                    end else begin
                        w_pop     = 1'b1;
                        w_pc_next = r_stack[w_top_idx];
                    end
                end
                default: ;
            endcase
            if (w_alu) begin
                w_wr_en  = 1'b1;
                w_result = w_sum[DATA_W-1:0];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            r_div    <= '0;
            r_pc     <= '0;
            r_regs   <= '0;
            r_out    <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_strobe <= 1'b0;
            r_sp     <= '0;
        end else begin
            r_div    <= w_tick ? '0 : r_div + 1'b1;
            r_pc     <= w_pc_next;
            r_strobe <= w_out_we;
            if (w_wr_en) r_regs[w_rd] <= w_result;
            if (w_alu) begin
                r_carry <= w_sum[DATA_W];
                r_zero  <= (w_sum[DATA_W-1:0] == '0);
            end
            if (w_out_we) r_out <= w_b;
            if (w_push)   r_sp  <= r_sp + 1'b1;
            if (w_pop)    r_sp  <= r_sp - 1'b1;
        end
    end

    // Stack contents need no reset: the pointer alone defines validity.
    always_ff @(posedge clock) begin
        if (!Reset && w_push) r_stack[w_push_idx] <= r_pc + 1'b1;
    end

    assign instr_addr = r_pc;
    assign out_data   = r_out;
    assign out_strobe = r_strobe;
    assign carry      = r_carry;
    assign zero       = r_zero;
    assign fault      = (r_state == S_FAULT);

endmodule
